// File: rtl/map_pkg.sv
// Shared definitions for the 1D<->2D address mappers: default widths and FSM encoding.
package map_pkg;

    localparam int MAP_POS_W = 14;
    localparam int MAP_DIM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } map_state_t;

endpackage

// File: rtl/map_to_2d_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int POS_W = 14,
    parameter int DIM_W = 8
) (
    input  logic [POS_W-1:0] r_in,
    input  logic             q_msb,
    input  logic [DIM_W-1:0] divisor,
    output logic [POS_W-1:0] r_out,
    output logic             qbit
);

    // One extra bit so the shifted remainder can never wrap before the compare.
    logic [POS_W:0] r_shift;
    logic [POS_W:0] dvsr_ext;

    always_comb begin
        r_shift  = {r_in, q_msb};
        dvsr_ext = (POS_W+1)'(divisor);
        qbit     = (r_shift >= dvsr_ext);
        r_out    = qbit ? POS_W'(r_shift - dvsr_ext) : POS_W'(r_shift);
    end

endmodule

// File: rtl/map_to_2d.sv
// Linear position -> (row, column) via a bit-serial restoring divider.
// Optional MAP_TO_2D_ERR_EN adds an err output and a fast path for width==0.
module map_to_2d
    import map_pkg::*;
#(
    parameter int POS_W = MAP_POS_W,
    parameter int DIM_W = MAP_DIM_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POS_W-1:0] pos1D,
    input  logic [DIM_W-1:0] width,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic             ovf
`ifdef MAP_TO_2D_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int CNT_W = $clog2(POS_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(POS_W - 1);

    map_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] quot;
    logic [POS_W-1:0] rem;
    logic [DIM_W-1:0] dvsr;

    logic [POS_W-1:0] r_next;
    logic             qbit;
    logic [POS_W-1:0] q_next;

    // The dividend register doubles as the quotient: its MSB feeds the step
    // while the new quotient bit enters at the LSB.
    div_step #(
        .POS_W (POS_W),
        .DIM_W (DIM_W)
    ) u_step (
        .r_in    (rem),
        .q_msb   (quot[POS_W-1]),
        .divisor (dvsr),
        .r_out   (r_next),
        .qbit    (qbit)
    );

    assign q_next    = {quot[POS_W-2:0], qbit};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            dvsr  <= '0;
            x     <= '0;
            y     <= '0;
            ovf   <= 1'b0;
`ifdef MAP_TO_2D_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quot <= pos1D;
                        dvsr <= width;
                        rem  <= '0;
                        cnt  <= '0;
`ifdef MAP_TO_2D_ERR_EN
                        if (width == '0) begin
                            err   <= 1'b1;
                            x     <= '0;
                            y     <= '0;
                            ovf   <= 1'b0;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= DIV;
                        end
`else
                        state <= DIV;
`endif
                    end
                end
                DIV: begin
                    rem  <= r_next;
                    quot <= q_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        x     <= q_next[DIM_W-1:0];
                        y     <= r_next[DIM_W-1:0];
                        ovf   <= |q_next[POS_W-1:DIM_W];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_to_2d.sv
// Scoreboard bench for map_to_2d: driver pushes hand-computed results, monitor
// pops and compares on every output handshake and checks accept->valid latency.
module tb_map_to_2d;
    import map_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] pos1D = '0;
    logic [7:0]  width = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  x, y;
    logic        ovf;
`ifdef MAP_TO_2D_ERR_EN
    logic        err;
`endif

    map_to_2d dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pos1D     (pos1D),
        .width     (width),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .ovf       (ovf)
`ifdef MAP_TO_2D_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       ovf;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    bit   seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor
    always @(negedge Clk) begin
        if (Rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                if (out_ready) chk("unexpected_output", 1, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                    seen = 1;
                end
                if (out_ready) begin
                    chk("x", x, sb[0].x);
                    chk("y", y, sb[0].y);
                    chk("ovf", ovf, sb[0].ovf);
`ifdef MAP_TO_2D_ERR_EN
                    chk("err", err, sb[0].err);
`endif
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic submit(input int p, input int w, input bit push,
                          input int ex, input int ey, input bit eovf,
                          input bit eerr, input int lat);
        int   n = 0;
        exp_t e;
        @(posedge Clk);
        #1;
        pos1D    = 14'(p);
        width    = 8'(w);
        in_valid = 1'b1;
        do begin
            @(negedge Clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.x   = ex[7:0];
            e.y   = ey[7:0];
            e.ovf = eovf;
            e.err = eerr;
            e.lat = lat;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        pos1D    = 14'($urandom);
        width    = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge Clk);
        #1 Rst = 1'b0;

        submit(645, 64, 1, 10, 5, 0, 0, 14);
        submit(200, 1, 1, 200, 0, 0, 0, 14);
        submit(300, 1, 1, 44, 0, 1, 0, 14);
`ifdef MAP_TO_2D_ERR_EN
        submit(77, 0, 1, 0, 0, 0, 1, 1);
`else
        submit(77, 0, 1, 255, 77, 1, 0, 14);
`endif
        submit(1000, 33, 1, 30, 10, 0, 0, 14);
        drain();

        // Hold the result in DONE and confirm it stays put.
        rdy_mode = 2;
        submit(500, 7, 1, 71, 3, 0, 0, 14);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!out_valid && n < 100);
        chk("hold_reach_done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_x", x, 71);
            chk("hold_y", y, 3);
        end
        rdy_mode = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);

        // Reset in the middle of a divide discards the job.
        submit(3000, 9, 0, 0, 0, 0, 0, 14);
        repeat (5) @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_x", x, 0);
        chk("midrst_y", y, 0);
        submit(123, 10, 1, 12, 3, 0, 0, 14);
        drain();

        rdy_mode = 1;
        for (int xx = 0; xx < 64; xx += 9) begin
            for (int yy = 0; yy < 64; yy += 9) begin
                submit(xx * 64 + yy, 64, 1, xx, yy, 0, 0, 14);
            end
        end
        drain();
        rdy_mode = 0;
        repeat (4) @(posedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
